// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//   Micro-operation sequencer for the SAP-style CPU. Walks fetch stages
//   T0..T2 and opcode-dependent execute stages T3..T5. It returns to T0 right
//   after an opcode's last active stage. It also supports conditional jumps on
//   carry/zero, a resumable HALT state and a valid-gated programming path.
//   The stage register advances on posedge clk. Every output is re-registered
//   on negedge clk, so outputs are stable around each rising edge.
//
// Ports
//   clk          system clock
//   resetn       asynchronous active-low reset
//   opcode       IR opcode field (valid from T3)
//   carry_flag   adder carry, used by JC at T3
//   zero_flag    accumulator-zero flag, used by JZ at T3
//   programming  programming-mode request, latched at T0
//   prog_valid   external programming byte is valid
//   resume       leave HALT
//   out          15-bit control word (idle 15'h0FE3)
//   done_load    programming byte written (T4 of a programming cycle)
//   read_ui_in   sample external byte (T3 of a programming cycle)
//   ready        high during T0
//   halted       high in HALT
//   stage        0..5 = T0..T5, 6 = IDLE, 7 = HALT
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter int OPCODE_W        = 4,
    parameter int HALT_ON_UNKNOWN = 0,
    parameter int PROG_STALL      = 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    input  logic                programming,
    input  logic                prog_valid,
    input  logic                resume,
    output logic [14:0]         out,
    output logic                done_load,
    output logic                read_ui_in,
    output logic                ready,
    output logic                halted,
    output logic [2:0]          stage
);

    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_T5   = 3'd5,
        ST_IDLE = 3'd6,
        ST_HALT = 3'd7
    } stage_e;

    // Idle control word: all active-low strobes deasserted, all active-high off.
    localparam logic [14:0] CW_IDLE = 15'h0FE3;

    localparam int B_PC_EN           = 13;
    localparam int B_PC_LOAD         = 12;
    localparam int B_MAR_ADDR_LOAD_N = 11;
    localparam int B_MAR_MEM_LOAD_N  = 10;
    localparam int B_RAM_EN_N        = 9;
    localparam int B_RAM_LOAD_N      = 8;
    localparam int B_IR_LOAD_N       = 7;
    localparam int B_IR_EN_N         = 6;
    localparam int B_REGA_LOAD_N     = 5;
    localparam int B_REGA_EN         = 4;
    localparam int B_ADDER_SUB       = 3;
    localparam int B_REGB_EN         = 2;
    localparam int B_REGB_LOAD_N     = 1;
    localparam int B_OUT_LOAD_N      = 0;

    localparam logic [3:0] OP_HLT = 4'd0;
    localparam logic [3:0] OP_NOP = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_LDA = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd5;
    localparam logic [3:0] OP_STA = 4'd6;
    localparam logic [3:0] OP_JMP = 4'd7;
    localparam logic [3:0] OP_JC  = 4'd8;
    localparam logic [3:0] OP_JZ  = 4'd9;

    stage_e      r_stage;
    stage_e      w_stage_next;
    logic        r_mode;
    logic [14:0] r_out;
    logic [14:0] w_out;
    logic        r_done_load, w_done_load;
    logic        r_read_ui_in, w_read_ui_in;
    logic        r_ready, w_ready;
    logic        r_halted, w_halted;
    logic [2:0]  r_stage_out;

    logic [3:0]  w_op;
    logic        w_op_known;
    logic        w_mem_op;
    logic        w_prog_stall;

    // Anything outside 0..9 (including wide opcodes with upper bits set) is unknown.
    assign w_op         = opcode[3:0];
    assign w_op_known   = (opcode <= OPCODE_W'(9));
    // Opcodes that need the operand-address fetch and continue past T3.
    assign w_mem_op     = w_op_known &&
                          ((w_op == OP_ADD) || (w_op == OP_SUB) ||
                           (w_op == OP_LDA) || (w_op == OP_STA));
    assign w_prog_stall = (PROG_STALL != 0) && !prog_valid;

    // Next-stage logic
    always_comb begin
        w_stage_next = r_stage;
        case (r_stage)
            ST_IDLE: w_stage_next = ST_T0;
            ST_T0:   w_stage_next = ST_T1;
            ST_T1:   w_stage_next = ST_T2;
            ST_T2: begin
                if (!(r_mode && w_prog_stall)) begin
                    w_stage_next = ST_T3;
                end
            end
            ST_T3: begin
                if (r_mode) begin
                    w_stage_next = ST_T4;
                end else if (!w_op_known) begin
                    if (HALT_ON_UNKNOWN != 0) begin
                        w_stage_next = ST_HALT;
                    end else begin
                        w_stage_next = ST_T0;
                    end
                end else if (w_op == OP_HLT) begin
                    w_stage_next = ST_HALT;
                end else if (w_mem_op) begin
                    w_stage_next = ST_T4;
                end else begin
                    w_stage_next = ST_T0;
                end
            end
            ST_T4: begin
                // LDA finishes here; ADD/SUB/STA need one more stage.
                if (!r_mode && w_mem_op && (w_op != OP_LDA)) begin
                    w_stage_next = ST_T5;
                end else begin
                    w_stage_next = ST_T0;
                end
            end
            ST_T5:   w_stage_next = ST_T0;
            ST_HALT: begin
                if (resume) begin
                    w_stage_next = ST_T0;
                end
            end
            default: w_stage_next = ST_IDLE;
        endcase
    end

    // Output decode from the current stage
    always_comb begin
        w_out        = CW_IDLE;
        w_done_load  = 1'b0;
        w_read_ui_in = 1'b0;
        w_ready      = 1'b0;
        w_halted     = 1'b0;
        case (r_stage)
            ST_T0: begin
                w_out[B_PC_EN]           = 1'b1;
                w_out[B_MAR_ADDR_LOAD_N] = 1'b0;
                w_ready                  = 1'b1;
            end
            ST_T2: begin
                if (!r_mode) begin
                    w_out[B_RAM_EN_N]  = 1'b0;
                    w_out[B_IR_LOAD_N] = 1'b0;
                end
            end
            ST_T3: begin
                if (r_mode) begin
                    w_out[B_PC_EN]          = 1'b1;
                    w_out[B_MAR_MEM_LOAD_N] = 1'b0;
                    w_read_ui_in            = 1'b1;
                end else if (!w_op_known) begin
                    w_out[B_PC_EN] = 1'b1;
                end else begin
                    case (w_op)
                        OP_ADD, OP_SUB, OP_LDA, OP_STA: begin
                            w_out[B_PC_EN]           = 1'b1;
                            w_out[B_IR_EN_N]         = 1'b0;
                            w_out[B_MAR_ADDR_LOAD_N] = 1'b0;
                        end
                        OP_OUT: begin
                            w_out[B_PC_EN]      = 1'b1;
                            w_out[B_REGA_EN]    = 1'b1;
                            w_out[B_OUT_LOAD_N] = 1'b0;
                        end
                        OP_JMP: begin
                            w_out[B_IR_EN_N] = 1'b0;
                            w_out[B_PC_LOAD] = 1'b1;
                        end
                        OP_JC, OP_JZ: begin
                            // Taken jump loads PC from IR; otherwise skip the operand.
                            if ((w_op == OP_JC) ? carry_flag : zero_flag) begin
                                w_out[B_IR_EN_N] = 1'b0;
                                w_out[B_PC_LOAD] = 1'b1;
                            end else begin
                                w_out[B_PC_EN] = 1'b1;
                            end
                        end
                        default: w_out[B_PC_EN] = 1'b1;  // HLT, NOP
                    endcase
                end
            end
            ST_T4: begin
                if (r_mode) begin
                    w_out[B_RAM_LOAD_N] = 1'b0;
                    w_done_load         = 1'b1;
                end else if (w_mem_op) begin
                    case (w_op)
                        OP_LDA: begin
                            w_out[B_RAM_EN_N]    = 1'b0;
                            w_out[B_REGA_LOAD_N] = 1'b0;
                        end
                        OP_STA: begin
                            w_out[B_REGA_EN]        = 1'b1;
                            w_out[B_MAR_MEM_LOAD_N] = 1'b0;
                        end
                        default: begin  // ADD, SUB
                            w_out[B_RAM_EN_N]    = 1'b0;
                            w_out[B_REGB_LOAD_N] = 1'b0;
                        end
                    endcase
                end
            end
            ST_T5: begin
                if (!r_mode && w_mem_op) begin
                    case (w_op)
                        OP_ADD, OP_SUB: begin
                            w_out[B_ADDER_SUB]   = (w_op == OP_SUB);
                            w_out[B_REGB_EN]     = 1'b1;
                            w_out[B_REGA_LOAD_N] = 1'b0;
                        end
                        OP_STA:  w_out[B_RAM_LOAD_N] = 1'b0;
                        default: ;
                    endcase
                end
            end
            ST_HALT: w_halted = 1'b1;
            default: ;
        endcase
    end

    // Stage register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stage <= ST_IDLE;
        end else begin
            r_stage <= w_stage_next;
        end
    end

    // Output registers and mode latch. Both update on the falling edge.
    always_ff @(negedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out        <= CW_IDLE;
            r_done_load  <= 1'b0;
            r_read_ui_in <= 1'b0;
            r_ready      <= 1'b0;
            r_halted     <= 1'b0;
            r_stage_out  <= ST_IDLE;
            r_mode       <= 1'b0;
        end else begin
            r_out        <= w_out;
            r_done_load  <= w_done_load;
            r_read_ui_in <= w_read_ui_in;
            r_ready      <= w_ready;
            r_halted     <= w_halted;
            r_stage_out  <= r_stage;
            // The mode is frozen for the rest of the instruction once captured.
            if (r_stage == ST_T0) begin
                r_mode <= programming;
            end
        end
    end

    assign out        = r_out;
    assign done_load  = r_done_load;
    assign read_ui_in = r_read_ui_in;
    assign ready      = r_ready;
    assign halted     = r_halted;
    assign stage      = r_stage_out;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
//   Table-driven bench for control_sequencer, with a scoreboard queue. Each
//   vector is one clock cycle. Inputs are driven just after posedge, and the
//   expected record is pushed to the queue at that point. The record is popped
//   and compared just after the following negedge, once the outputs have
//   registered. A second instance with HALT_ON_UNKNOWN=1 covers unknown-opcode
//   halting. That instance is held in reset until its own sequence runs.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    localparam logic [14:0] W_IDLE = 15'h0FE3;
    localparam logic [14:0] W_T0   = 15'h27E3;
    localparam logic [14:0] W_T2X  = 15'h0D63;
    localparam logic [14:0] W_PCEN = 15'h2FE3;
    localparam logic [14:0] W_T3M  = 15'h27A3;
    localparam logic [14:0] W_OUT3 = 15'h2FF2;
    localparam logic [14:0] W_JMP  = 15'h1FA3;
    localparam logic [14:0] W_ADD4 = 15'h0DE1;
    localparam logic [14:0] W_LDA4 = 15'h0DC3;
    localparam logic [14:0] W_STA4 = 15'h0BF3;
    localparam logic [14:0] W_ADD5 = 15'h0FC7;
    localparam logic [14:0] W_SUB5 = 15'h0FCF;
    localparam logic [14:0] W_STA5 = 15'h0EE3;
    localparam logic [14:0] W_PRG3 = 15'h2BE3;
    localparam logic [14:0] W_PRG4 = 15'h0EE3;

    // flag nibble = {ready, read_ui_in, done_load, halted}
    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_RDY  = 4'b1000;
    localparam logic [3:0] F_RD   = 4'b0100;
    localparam logic [3:0] F_DN   = 4'b0010;
    localparam logic [3:0] F_HLT  = 4'b0001;

    logic        clk = 1'b0;
    logic        resetn, resetn_h;
    logic [3:0]  opcode;
    logic        carry_flag, zero_flag, programming, prog_valid, resume;
    logic [14:0] out, out_h;
    logic        done_load, read_ui_in, ready, halted;
    logic        done_load_h, read_ui_in_h, ready_h, halted_h;
    logic [2:0]  stage, stage_h;

    always #5 clk = ~clk;

    control_sequencer u_dut (
        .clk(clk), .resetn(resetn), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .programming(programming), .prog_valid(prog_valid), .resume(resume),
        .out(out), .done_load(done_load), .read_ui_in(read_ui_in),
        .ready(ready), .halted(halted), .stage(stage)
    );

    control_sequencer #(.HALT_ON_UNKNOWN(1)) u_dut_h (
        .clk(clk), .resetn(resetn_h), .opcode(opcode),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .programming(programming), .prog_valid(prog_valid), .resume(resume),
        .out(out_h), .done_load(done_load_h), .read_ui_in(read_ui_in_h),
        .ready(ready_h), .halted(halted_h), .stage(stage_h)
    );

    typedef struct {
        logic [3:0]  op;
        logic        prog;
        logic        pv;
        logic        cy;
        logic        zf;
        logic        res;
        logic [2:0]  stg;
        logic [14:0] cw;
        logic [3:0]  fl;
    } vec_t;

    typedef struct {
        bit          h;
        string       tag;
        logic [2:0]  stg;
        logic [14:0] cw;
        logic [3:0]  fl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard: queue empty, got 1 expected 0");
            return;
        end
        e = sb_q.pop_front();
        if (e.h) begin
            chk({e.tag, " stage"}, {29'd0, stage_h}, {29'd0, e.stg});
            chk({e.tag, " out"}, {17'd0, out_h}, {17'd0, e.cw});
            chk({e.tag, " flags"}, {28'd0, ready_h, read_ui_in_h, done_load_h, halted_h},
                {28'd0, e.fl});
        end else begin
            chk({e.tag, " stage"}, {29'd0, stage}, {29'd0, e.stg});
            chk({e.tag, " out"}, {17'd0, out}, {17'd0, e.cw});
            chk({e.tag, " flags"}, {28'd0, ready, read_ui_in, done_load, halted},
                {28'd0, e.fl});
        end
        $display("cycle %s: stage=%0d out=%h", e.tag, e.h ? stage_h : stage, e.h ? out_h : out);
    endtask

    // One cycle: drive, push the expectation, compare after negedge, move past posedge.
    task automatic apply(input vec_t v, input bit h, input string tag);
        exp_t e;
        opcode      = v.op;
        programming = v.prog;
        prog_valid  = v.pv;
        carry_flag  = v.cy;
        zero_flag   = v.zf;
        resume      = v.res;
        e.h = h; e.tag = tag; e.stg = v.stg; e.cw = v.cw; e.fl = v.fl;
        sb_q.push_back(e);
        @(negedge clk);
        #1;
        check_pop();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [3:0] op, input logic prog, input logic pv,
                                input logic cy, input logic zf, input logic res,
                                input logic [2:0] stg, input logic [14:0] cw,
                                input logic [3:0] fl);
        vec_t v;
        v.op = op; v.prog = prog; v.pv = pv; v.cy = cy; v.zf = zf; v.res = res;
        v.stg = stg; v.cw = cw; v.fl = fl;
        return v;
    endfunction

    task automatic add(input logic [3:0] op, input logic prog, input logic pv,
                       input logic cy, input logic zf, input logic res,
                       input logic [2:0] stg, input logic [14:0] cw, input logic [3:0] fl);
        vecs.push_back(mk(op, prog, pv, cy, zf, res, stg, cw, fl));
    endtask

    task automatic add_fetch(input logic [3:0] op);
        add(op, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, W_T0,   F_RDY);
        add(op, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, W_IDLE, F_NONE);
        add(op, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, W_T2X,  F_NONE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        resetn = 1'b1; resetn_h = 1'b1;
        opcode = 4'd2; carry_flag = 1'b0; zero_flag = 1'b0;
        programming = 1'b0; prog_valid = 1'b1; resume = 1'b0;

        // Reset asserted between clock edges must act immediately.
        #2 resetn = 1'b0; resetn_h = 1'b0;
        #1;
        chk("reset out", {17'd0, out}, {17'd0, W_IDLE});
        chk("reset stage", {29'd0, stage}, 32'd6);
        chk("reset flags", {28'd0, ready, read_ui_in, done_load, halted}, 32'd0);

        // ADD from reset release: 6,0,1,2,3,4,5
        add(4'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd6, W_IDLE, F_NONE);
        add_fetch(4'd2);
        add(4'd2, 0, 1, 0, 0, 0, 3'd3, W_T3M,  F_NONE);
        add(4'd2, 0, 1, 0, 0, 0, 3'd4, W_ADD4, F_NONE);
        add(4'd2, 0, 1, 0, 0, 0, 3'd5, W_ADD5, F_NONE);
        // OUT (4 cycles) then LDA (5 cycles)
        add_fetch(4'd5);
        add(4'd5, 0, 1, 0, 0, 0, 3'd3, W_OUT3, F_NONE);
        add_fetch(4'd4);
        add(4'd4, 0, 1, 0, 0, 0, 3'd3, W_T3M,  F_NONE);
        add(4'd4, 0, 1, 0, 0, 0, 3'd4, W_LDA4, F_NONE);
        // SUB
        add_fetch(4'd3);
        add(4'd3, 0, 1, 0, 0, 0, 3'd3, W_T3M,  F_NONE);
        add(4'd3, 0, 1, 0, 0, 0, 3'd4, W_ADD4, F_NONE);
        add(4'd3, 0, 1, 0, 0, 0, 3'd5, W_SUB5, F_NONE);
        // JMP, JC taken/not taken, JZ taken/not taken
        add_fetch(4'd7);
        add(4'd7, 0, 1, 0, 0, 0, 3'd3, W_JMP,  F_NONE);
        add_fetch(4'd8);
        add(4'd8, 0, 1, 1, 0, 0, 3'd3, W_JMP,  F_NONE);
        add_fetch(4'd8);
        add(4'd8, 0, 1, 0, 1, 0, 3'd3, W_PCEN, F_NONE);
        add_fetch(4'd9);
        add(4'd9, 0, 1, 0, 1, 0, 3'd3, W_JMP,  F_NONE);
        add_fetch(4'd9);
        add(4'd9, 0, 1, 1, 0, 0, 3'd3, W_PCEN, F_NONE);
        // STA
        add_fetch(4'd6);
        add(4'd6, 0, 1, 0, 0, 0, 3'd3, W_T3M,  F_NONE);
        add(4'd6, 0, 1, 0, 0, 0, 3'd4, W_STA4, F_NONE);
        add(4'd6, 0, 1, 0, 0, 0, 3'd5, W_STA5, F_NONE);
        // NOP with resume pulsed outside HALT (ignored)
        add(4'd1, 0, 1, 0, 0, 0, 3'd0, W_T0,   F_RDY);
        add(4'd1, 0, 1, 0, 0, 1, 3'd1, W_IDLE, F_NONE);
        add(4'd1, 0, 1, 0, 0, 0, 3'd2, W_T2X,  F_NONE);
        add(4'd1, 0, 1, 0, 0, 0, 3'd3, W_PCEN, F_NONE);
        // Unknown opcode with HALT_ON_UNKNOWN=0 behaves as NOP
        add_fetch(4'hF);
        add(4'hF, 0, 1, 0, 0, 0, 3'd3, W_PCEN, F_NONE);
        // Programming byte with 3 stall cycles; programming drops during T3
        add(4'd1, 1, 1, 0, 0, 0, 3'd0, W_T0,   F_RDY);
        add(4'd1, 1, 1, 0, 0, 0, 3'd1, W_IDLE, F_NONE);
        add(4'd1, 1, 0, 0, 0, 0, 3'd2, W_IDLE, F_NONE);
        add(4'd1, 1, 0, 0, 0, 0, 3'd2, W_IDLE, F_NONE);
        add(4'd1, 1, 0, 0, 0, 0, 3'd2, W_IDLE, F_NONE);
        add(4'd1, 1, 1, 0, 0, 0, 3'd2, W_IDLE, F_NONE);
        add(4'd1, 0, 1, 0, 0, 0, 3'd3, W_PRG3, F_RD);
        add(4'd1, 0, 1, 0, 0, 0, 3'd4, W_PRG4, F_DN);
        // Back to execute mode: T2 must show the IR fetch again
        add_fetch(4'd1);
        add(4'd1, 0, 1, 0, 0, 0, 3'd3, W_PCEN, F_NONE);
        // HLT, stay halted, then resume
        add_fetch(4'd0);
        add(4'd0, 0, 1, 0, 0, 0, 3'd3, W_PCEN, F_NONE);
        add(4'd0, 0, 1, 0, 0, 0, 3'd7, W_IDLE, F_HLT);
        add(4'd0, 0, 1, 0, 0, 0, 3'd7, W_IDLE, F_HLT);
        add(4'd0, 0, 1, 0, 0, 0, 3'd7, W_IDLE, F_HLT);
        add(4'd0, 0, 1, 0, 0, 1, 3'd7, W_IDLE, F_HLT);
        add_fetch(4'd1);
        add(4'd1, 0, 1, 0, 0, 0, 3'd3, W_PCEN, F_NONE);

        @(posedge clk);
        #1;
        resetn = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], 1'b0, $sformatf("v%0d", i));
        end

        // STA interrupted by reset in the middle of T4
        apply(mk(4'd6, 0, 1, 0, 0, 0, 3'd0, W_T0,   F_RDY),  1'b0, "sta_t0");
        apply(mk(4'd6, 0, 1, 0, 0, 0, 3'd1, W_IDLE, F_NONE), 1'b0, "sta_t1");
        apply(mk(4'd6, 0, 1, 0, 0, 0, 3'd2, W_T2X,  F_NONE), 1'b0, "sta_t2");
        apply(mk(4'd6, 0, 1, 0, 0, 0, 3'd3, W_T3M,  F_NONE), 1'b0, "sta_t3");
        sb_q.push_back('{1'b0, "sta_t4", 3'd4, W_STA4, F_NONE});
        @(negedge clk);
        #1;
        check_pop();
        #1 resetn = 1'b0;
        #1;
        chk("async rst out", {17'd0, out}, {17'd0, W_IDLE});
        chk("async rst stage", {29'd0, stage}, 32'd6);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        apply(mk(4'd1, 0, 1, 0, 0, 0, 3'd6, W_IDLE, F_NONE), 1'b0, "rr_idle");
        apply(mk(4'd1, 0, 1, 0, 0, 0, 3'd0, W_T0,   F_RDY),  1'b0, "rr_t0");
        apply(mk(4'd1, 0, 1, 0, 0, 0, 3'd1, W_IDLE, F_NONE), 1'b0, "rr_t1");

        // HALT_ON_UNKNOWN=1 instance with opcode 4'hF
        resetn_h = 1'b1;
        apply(mk(4'hF, 0, 1, 0, 0, 0, 3'd6, W_IDLE, F_NONE), 1'b1, "h_idle");
        apply(mk(4'hF, 0, 1, 0, 0, 0, 3'd0, W_T0,   F_RDY),  1'b1, "h_t0");
        apply(mk(4'hF, 0, 1, 0, 0, 0, 3'd1, W_IDLE, F_NONE), 1'b1, "h_t1");
        apply(mk(4'hF, 0, 1, 0, 0, 0, 3'd2, W_T2X,  F_NONE), 1'b1, "h_t2");
        apply(mk(4'hF, 0, 1, 0, 0, 0, 3'd3, W_PCEN, F_NONE), 1'b1, "h_t3");
        apply(mk(4'hF, 0, 1, 0, 0, 0, 3'd7, W_IDLE, F_HLT),  1'b1, "h_halt0");
        apply(mk(4'hF, 0, 1, 0, 0, 0, 3'd7, W_IDLE, F_HLT),  1'b1, "h_halt1");
        apply(mk(4'hF, 0, 1, 0, 0, 1, 3'd7, W_IDLE, F_HLT),  1'b1, "h_resume");
        apply(mk(4'd1, 0, 1, 0, 0, 0, 3'd0, W_T0,   F_RDY),  1'b1, "h_t0b");

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard drain: got %0d expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
